// File: rtl/io_input_ctrl.sv
// io_input_ctrl: read-switches port for MiniRiscV. It synchronises and debounces the button, then completes a stalling rd_req/rd_ack handshake.
// When IO_PRESS_BUFFER_EN is defined, a press that arrives before the request is buffered, and pending shows it.
module io_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SW_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            button,
   input  logic [SW_W-1:0] switches,
   input  logic            rd_req,
   output logic            rd_ack,
   output logic [31:0]     rd_data,
   output logic            stall,
   output logic            btn_pulse,
   output logic            pending
);
   localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
`ifdef IO_PRESS_BUFFER_EN
   localparam logic BUF = 1'b1;
`else
   localparam logic BUF = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, ARMED, ACK} state_t;
   state_t state, state_nx;
   logic btn_m, btn_s, db, db_q, capture;
   logic [SW_W-1:0] sw_m, sw_s;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         btn_m <= 1'b0;
         btn_s <= 1'b0;
         sw_m  <= '0;
         sw_s  <= '0;
      end else begin
         btn_m <= button;
         btn_s <= btn_m;
         sw_m  <= switches;
         sw_s  <= sw_m;
      end

   // db follows btn_s only after DEBOUNCE_CYCLES consecutive differing samples
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         db   <= 1'b0;
         db_q <= 1'b0;
         cnt  <= '0;
      end else begin
         db_q <= db;
         if (btn_s == db)
            cnt <= '0;
         else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            db  <= btn_s;
            cnt <= '0;
         end else
            cnt <= cnt + 1'b1;
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = rd_req ? ((btn_pulse || pending) ? ACK : ARMED) : IDLE;
         ARMED:   state_nx = btn_pulse ? ACK : (rd_req ? ARMED : IDLE);
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      btn_pulse = db & ~db_q;
      rd_ack    = state == ACK;
      stall     = rd_req & ~rd_ack;
      capture   = btn_pulse & ((state == ARMED) | ((state == IDLE) & (rd_req | BUF)));
   end

   always_ff @(posedge clk or posedge rst)
      if (rst)          rd_data <= '0;
      else if (capture) rd_data <= 32'(sw_s);

`ifdef IO_PRESS_BUFFER_EN
   // a request in IDLE consumes the buffered press; presses outside IDLE are dropped
   always_ff @(posedge clk or posedge rst)
      if (rst)                 pending <= 1'b0;
      else if (state == IDLE)  pending <= rd_req ? 1'b0 : (pending | btn_pulse);
`else
   assign pending = 1'b0;
`endif
endmodule

// File: tb/tb_io_input_ctrl.sv
// tb_io_input_ctrl: vector table, directed corner sequences and a randomized run against a behavioural model.
module tb_io_input_ctrl;
   localparam int DC = 4;
   localparam int RAND_CYC = 3000;
`ifdef IO_PRESS_BUFFER_EN
   localparam logic BUF = 1'b1;
`else
   localparam logic BUF = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b0, button = 1'b0, rd_req = 1'b0;
   logic [7:0] switches = 8'h00;
   logic rd_ack, stall, btn_pulse, pending;
   logic [31:0] rd_data, last_data;
   int tests = 0, fails = 0, np = 0, na = 0;

   io_input_ctrl #(.DEBOUNCE_CYCLES(DC), .SW_W(8)) dut (
      .clk(clk), .rst(rst), .button(button), .switches(switches), .rd_req(rd_req),
      .rd_ack(rd_ack), .rd_data(rd_data), .stall(stall), .btn_pulse(btn_pulse), .pending(pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic b; logic [7:0] sw; logic req;
      logic pulse; logic ack; logic stl; logic pend; logic [31:0] data;
   } vec_t;
   vec_t tbl[12];

   logic bh[RAND_CYC];
   logic [7:0] swh[RAND_CYC];
   logic m_db, m_dbq, m_ack, m_armed, m_pend;
   logic [31:0] m_data;

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (btn_pulse) np++;
         if (rd_ack) begin
            na++;
            last_data = rd_data;
            rd_req = 1'b0;
         end
      end
   endtask

   task automatic do_reset;
      @(posedge clk);
      #4 rst = 1'b1;
      #1;
      check("rst_ack", 40'(rd_ack), 40'd0);
      check("rst_data", 40'(rd_data), 40'd0);
      check("rst_pulse", 40'(btn_pulse), 40'd0);
      check("rst_pending", 40'(pending), 40'd0);
      check("rst_stall", 40'(stall), 40'(rd_req));
      #16 rst = 1'b0;
      @(negedge clk);
      np = 0;
      na = 0;
   endtask

   function automatic logic bs_at(input int t);
      return (t >= 2) ? bh[t-2] : 1'b0;
   endfunction

   // one clock edge of the reference: handshake rules, then debounce as "last DC synced samples all differ"
   task automatic model_step(input int t, input logic r);
      logic p, flip;
      logic [7:0] sws;
      bh[t] = button;
      swh[t] = switches;
      p = m_db & ~m_dbq;
      sws = (t >= 2) ? swh[t-2] : 8'h00;
      if (m_ack) m_ack = 1'b0;
      else if (m_armed) begin
         if (p) begin m_data = {24'h0, sws}; m_ack = 1'b1; m_armed = 1'b0; end
         else if (!r) m_armed = 1'b0;
      end else if (r) begin
         if (p) begin m_data = {24'h0, sws}; m_ack = 1'b1; m_pend = 1'b0; end
         else if (m_pend) begin m_ack = 1'b1; m_pend = 1'b0; end
         else m_armed = 1'b1;
      end else if (p && BUF) begin
         m_data = {24'h0, sws};
         m_pend = 1'b1;
      end
      flip = 1'b1;
      for (int j = 0; j < DC; j++) if (bs_at(t - j) == m_db) flip = 1'b0;
      m_dbq = m_db;
      if (flip) m_db = ~m_db;
   endtask

   initial begin
      int hold;
      logic bl;
      tbl[0]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
      tbl[2]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
      tbl[3]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
      tbl[4]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
      tbl[5]  = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
      tbl[6]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2};
      tbl[7]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2};
      tbl[8]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2};
      tbl[9]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2};
      tbl[10] = '{1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2};
      tbl[11] = '{1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2};

      do_reset;
      for (int i = 0; i < 12; i++) begin
         button = tbl[i].b;
         switches = tbl[i].sw;
         rd_req = tbl[i].req;
         @(negedge clk);
         check($sformatf("vec%0d", i), {4'h0, btn_pulse, rd_ack, stall, pending, rd_data},
               {4'h0, tbl[i].pulse, tbl[i].ack, tbl[i].stl, tbl[i].pend, tbl[i].data});
      end

      // asynchronous reset while waiting in ARMED
      rd_req = 1'b1;
      step_n(3);
      do_reset;
      rd_req = 1'b0;

      // bounce: 2-cycle toggles never settle, then a steady press
      do_reset;
      rd_req = 1'b1;
      switches = 8'h3C;
      for (int k = 0; k < 6; k++) begin
         button = (k % 2 == 0);
         step_n(2);
      end
      check("bounce_no_pulse", 40'(np), 40'd0);
      button = 1'b1;
      step_n(15);
      check("bounce_pulses", 40'(np), 40'd1);
      check("bounce_acks", 40'(na), 40'd1);
      check("bounce_data", 40'(last_data), 40'h3C);
      button = 1'b0;

      // press before the request
      do_reset;
      switches = 8'hA5;
      button = 1'b1;
      step_n(8);
      switches = 8'h00;
      button = 1'b0;
      step_n(8);
      check("early_pulses", 40'(np), 40'd1);
      check("early_pending", 40'(pending), 40'(BUF));
      check("early_data", 40'(rd_data), BUF ? 40'hA5 : 40'h0);
      na = 0;
      rd_req = 1'b1;
      step_n(1);
      check("early_ack_next", 40'(na), 40'(BUF));
      check("early_ack_data", 40'(last_data), BUF ? 40'hA5 : 40'(last_data));
      step_n(9);
      check("early_acks", 40'(na), 40'(BUF));
      check("early_stall", 40'(stall), 40'(!BUF));
      check("early_pending_clr", 40'(pending), 40'd0);
      rd_req = 1'b1;
      switches = 8'h5A;
      na = 0;
      button = 1'b1;
      step_n(12);
      check("early_second_ack", 40'(na), 40'd1);
      check("early_second_data", 40'(last_data), 40'h5A);
      button = 1'b0;

      // abort from ARMED, then a press with no request
      do_reset;
      rd_req = 1'b1;
      step_n(3);
      rd_req = 1'b0;
      step_n(2);
      check("abort_stall", 40'(stall), 40'd0);
      switches = 8'hC3;
      button = 1'b1;
      step_n(10);
      button = 1'b0;
      step_n(8);
      check("abort_pulses", 40'(np), 40'd1);
      check("abort_acks", 40'(na), 40'd0);
      check("abort_pending", 40'(pending), 40'(BUF));
      check("abort_data", 40'(rd_data), BUF ? 40'hC3 : 40'h0);

      // held button serves only one request
      do_reset;
      rd_req = 1'b1;
      switches = 8'h77;
      button = 1'b1;
      step_n(12);
      check("held_first_ack", 40'(na), 40'd1);
      check("held_first_data", 40'(last_data), 40'h77);
      na = 0;
      rd_req = 1'b1;
      switches = 8'h88;
      step_n(20);
      check("held_no_ack", 40'(na), 40'd0);
      check("held_stall", 40'(stall), 40'd1);
      button = 1'b0;
      step_n(8);
      button = 1'b1;
      step_n(10);
      check("held_repress_ack", 40'(na), 40'd1);
      check("held_repress_data", 40'(last_data), 40'h88);
      button = 1'b0;
      rd_req = 1'b0;

      // randomized run against the model
      do_reset;
      {m_db, m_dbq, m_ack, m_armed, m_pend} = '0;
      m_data = '0;
      hold = 0;
      bl = 1'b0;
      for (int t = 0; t < RAND_CYC; t++) begin
         if (hold == 0) begin
            bl = ~bl;
            hold = int'($urandom_range(1, 12));
         end
         hold--;
         button = bl;
         switches = 8'($urandom);
         if (m_ack) rd_req = 1'b0;
         else if (rd_req) begin
            if ($urandom_range(0, 39) == 0) rd_req = 1'b0;
         end else if ($urandom_range(0, 5) == 0) rd_req = 1'b1;
         model_step(t, rd_req);
         @(negedge clk);
         check($sformatf("rand%0d", t), {4'h0, rd_ack, btn_pulse, stall, pending, rd_data},
               {4'h0, m_ack, m_db & ~m_dbq, rd_req & ~m_ack, m_pend, m_data});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
